// File: rtl/mem_bus_if.sv
// Memory bus between the access unit (master) and the memory system (slave):
// a valid/ready request channel followed by a single-cycle response pulse.
interface mem_bus_if;
    logic        bus_req_valid_out;
    logic        bus_req_ready_in;
    logic        bus_write_out;
    logic [31:0] bus_addr_out;
    logic [31:0] bus_wdata_out;
    logic [3:0]  bus_wstrb_out;
    logic        bus_resp_valid_in;
    logic [31:0] bus_rdata_in;

    modport master (
        output bus_req_valid_out,
        output bus_write_out,
        output bus_addr_out,
        output bus_wdata_out,
        output bus_wstrb_out,
        input  bus_req_ready_in,
        input  bus_resp_valid_in,
        input  bus_rdata_in
    );

    modport slave (
        input  bus_req_valid_out,
        input  bus_write_out,
        input  bus_addr_out,
        input  bus_wdata_out,
        input  bus_wstrb_out,
        output bus_req_ready_in,
        output bus_resp_valid_in,
        output bus_rdata_in
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit for the MEM stage: checks alignment, places store data on
// the right byte lanes, runs one bus transaction at a time and sign/zero
// extends load data. The pipeline is held while a transaction is in flight.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_in,
    input  logic        mem_request_write_in,
    input  logic [2:0]  mem_request_size_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        stall_out,
    output logic        misaligned_out,
    mem_bus_if.master   bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [2:0]  size_q;
    logic [1:0]  offset_q;
    logic        legal;
    logic [31:0] wdata_next;
    logic [3:0]  wstrb_next;
    logic [31:0] rdata_shifted;
    logic [31:0] load_next;

    // Decide whether the presented request is a supported, naturally aligned access.
    always_comb begin
        legal = 1'b0;
        case (mem_request_size_in)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~addr_in[0];
            3'b010:  legal = (addr_in[1:0] == 2'b00);
            3'b100:  legal = ~mem_request_write_in;
            3'b101:  legal = ~mem_request_write_in & ~addr_in[0];
            default: legal = 1'b0;
        endcase
    end

    // Replicate store data across the lanes and enable only the addressed bytes.
    always_comb begin
        wdata_next = store_data_in;
        wstrb_next = 4'b0000;
        if (mem_request_write_in) begin
            case (mem_request_size_in[1:0])
                2'b00: begin
                    wdata_next = {4{store_data_in[7:0]}};
                    wstrb_next = 4'b0001 << addr_in[1:0];
                end
                2'b01: begin
                    wdata_next = {2{store_data_in[15:0]}};
                    wstrb_next = addr_in[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    wdata_next = store_data_in;
                    wstrb_next = 4'b1111;
                end
            endcase
        end
    end

    // Pull the addressed lane down to bit 0 and extend it according to the latched size.
    always_comb begin
        rdata_shifted = bus.bus_rdata_in >> {offset_q, 3'b000};
        case (size_q)
            3'b000:  load_next = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_next = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_next = {24'd0, rdata_shifted[7:0]};
            3'b101:  load_next = {16'd0, rdata_shifted[15:0]};
            default: load_next = bus.bus_rdata_in;
        endcase
    end

    // Hold the pipeline from the cycle a legal request appears until its response arrives.
    always_comb begin
        stall_out = ((state == IDLE) && req_valid_in && legal) ||
                    (state == REQ) || (state == WAIT);
    end

    // Transaction sequencer; the request fields stay latched so the bus sees stable values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            size_q                <= 3'b000;
            offset_q              <= 2'b00;
            bus.bus_req_valid_out <= 1'b0;
            bus.bus_write_out     <= 1'b0;
            bus.bus_addr_out      <= 32'd0;
            bus.bus_wdata_out     <= 32'd0;
            bus.bus_wstrb_out     <= 4'b0000;
            load_data_out         <= 32'd0;
            load_valid_out        <= 1'b0;
            misaligned_out        <= 1'b0;
        end else begin
            load_valid_out <= 1'b0;
            misaligned_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_in) begin
                        if (legal) begin
                            size_q                <= mem_request_size_in;
                            offset_q              <= addr_in[1:0];
                            bus.bus_write_out     <= mem_request_write_in;
                            bus.bus_addr_out      <= {addr_in[31:2], 2'b00};
                            bus.bus_wdata_out     <= wdata_next;
                            bus.bus_wstrb_out     <= wstrb_next;
                            bus.bus_req_valid_out <= 1'b1;
                            state                 <= REQ;
                        end else begin
                            misaligned_out <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus.bus_req_ready_in) begin
                        bus.bus_req_valid_out <= 1'b0;
                        state                 <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.bus_resp_valid_in) begin
                        if (!bus.bus_write_out) begin
                            load_data_out  <= load_next;
                            load_valid_out <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed corner cases followed by
// random loads/stores compared against a lane-level behavioural model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        load_valid;
    logic        stall;
    logic        misaligned;

    int vectors;
    int miscompares;
    int txn_count;
    logic [31:0] last_load;

    mem_bus_if bus_if ();

    mem_access_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid_in         (req_valid),
        .mem_request_write_in (write),
        .mem_request_size_in  (size),
        .addr_in              (addr),
        .store_data_in        (store_data),
        .load_data_out        (load_data),
        .load_valid_out       (load_valid),
        .stall_out            (stall),
        .misaligned_out       (misaligned),
        .bus                  (bus_if)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count every accepted bus request to catch missing or repeated transactions.
    always @(posedge clk) begin
        if (!rst && bus_if.bus_req_valid_out && bus_if.bus_req_ready_in)
            txn_count <= txn_count + 1;
    end

    // Hard stop in case the sequence ever stalls unexpectedly.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic int model_bytes(input logic [2:0] sz);
        return 1 << sz[1:0];
    endfunction

    function automatic logic model_legal(input logic wr, input logic [2:0] sz, input logic [31:0] a);
        int n;
        if (sz == 3'd3 || sz == 3'd6 || sz == 3'd7) return 1'b0;
        if (wr && sz[2]) return 1'b0;
        n = model_bytes(sz);
        if ((a % n) != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] model_wstrb(input logic wr, input logic [2:0] sz, input logic [31:0] a);
        int n;
        logic [7:0] m;
        if (!wr) return 4'b0000;
        n = model_bytes(sz);
        m = 8'((1 << n) - 1) << a[1:0];
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] sz, input logic [31:0] d);
        int n;
        logic [31:0] w;
        n = model_bytes(sz);
        w = 32'd0;
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] rdata);
        int n;
        logic [63:0] v;
        logic [63:0] mask;
        n = model_bytes(sz);
        v = {32'd0, rdata} >> (8 * a[1:0]);
        mask = (64'd1 << (8 * n)) - 64'd1;
        v = v & mask;
        if (!sz[2] && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // One memory operation presented at a falling edge; the bench plays the bus slave.
    task automatic applyStimulus(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                                 input logic [31:0] d, input logic [31:0] rdata,
                                 input int ready_delay, input int resp_delay);
        logic ok;
        int exp_txn;
        ok = model_legal(wr, sz, a);
        exp_txn = txn_count + (ok ? 1 : 0);
        req_valid = 1'b1;
        write = wr;
        size = sz;
        addr = a;
        store_data = d;
        bus_if.bus_req_ready_in = 1'b0;
        bus_if.bus_resp_valid_in = 1'b0;
        #1;
        checkOutput("stall_on_request", 32'(stall), 32'(ok));
        @(negedge clk);
        if (!ok) begin
            checkOutput("misaligned_pulse", 32'(misaligned), 32'd1);
            checkOutput("no_bus_request", 32'(bus_if.bus_req_valid_out), 32'd0);
            checkOutput("stall_after_illegal", 32'(stall), 32'd0);
            checkOutput("txn_count_illegal", 32'(txn_count), 32'(exp_txn));
            return;
        end
        for (int c = 0; c <= ready_delay; c++) begin
            checkOutput("req_valid", 32'(bus_if.bus_req_valid_out), 32'd1);
            checkOutput("req_write", 32'(bus_if.bus_write_out), 32'(wr));
            checkOutput("req_addr", bus_if.bus_addr_out, {a[31:2], 2'b00});
            checkOutput("req_wstrb", 32'(bus_if.bus_wstrb_out), 32'(model_wstrb(wr, sz, a)));
            if (wr) checkOutput("req_wdata", bus_if.bus_wdata_out, model_wdata(sz, d));
            checkOutput("stall_in_req", 32'(stall), 32'd1);
            checkOutput("no_misaligned", 32'(misaligned), 32'd0);
            if (c == ready_delay) bus_if.bus_req_ready_in = 1'b1;
            @(negedge clk);
        end
        bus_if.bus_req_ready_in = 1'b0;
        checkOutput("req_dropped", 32'(bus_if.bus_req_valid_out), 32'd0);
        for (int c = 0; c < resp_delay; c++) begin
            checkOutput("stall_in_wait", 32'(stall), 32'd1);
            checkOutput("no_early_load", 32'(load_valid), 32'd0);
            bus_if.bus_rdata_in = $urandom;
            @(negedge clk);
        end
        checkOutput("stall_in_wait", 32'(stall), 32'd1);
        bus_if.bus_resp_valid_in = 1'b1;
        bus_if.bus_rdata_in = rdata;
        @(negedge clk);
        bus_if.bus_resp_valid_in = 1'b0;
        bus_if.bus_rdata_in = $urandom;
        if (!wr) last_load = model_load(sz, a, rdata);
        checkOutput("load_valid_done", 32'(load_valid), 32'(!wr));
        checkOutput("load_data_done", load_data, last_load);
        checkOutput("stall_in_done", 32'(stall), 32'd0);
        @(negedge clk);
        checkOutput("load_valid_pulse_end", 32'(load_valid), 32'd0);
        checkOutput("load_data_hold", load_data, last_load);
        checkOutput("txn_count", 32'(txn_count), 32'(exp_txn));
    endtask

    // Let the pipeline sit empty for one cycle.
    task automatic idleCycle();
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("idle_stall", 32'(stall), 32'd0);
        checkOutput("idle_misaligned", 32'(misaligned), 32'd0);
        checkOutput("idle_req_valid", 32'(bus_if.bus_req_valid_out), 32'd0);
    endtask

    task automatic checkAllClear(input string tag);
        checkOutput({tag, "_req_valid"}, 32'(bus_if.bus_req_valid_out), 32'd0);
        checkOutput({tag, "_write"}, 32'(bus_if.bus_write_out), 32'd0);
        checkOutput({tag, "_addr"}, bus_if.bus_addr_out, 32'd0);
        checkOutput({tag, "_wdata"}, bus_if.bus_wdata_out, 32'd0);
        checkOutput({tag, "_wstrb"}, 32'(bus_if.bus_wstrb_out), 32'd0);
        checkOutput({tag, "_load_data"}, load_data, 32'd0);
        checkOutput({tag, "_load_valid"}, 32'(load_valid), 32'd0);
        checkOutput({tag, "_misaligned"}, 32'(misaligned), 32'd0);
        checkOutput({tag, "_stall"}, 32'(stall), 32'd0);
    endtask

    // Reset while waiting for a response; the late response must be ignored.
    task automatic resetInWait();
        req_valid = 1'b1;
        write = 1'b0;
        size = 3'b010;
        addr = 32'h0000_0500;
        store_data = 32'd0;
        @(negedge clk);
        bus_if.bus_req_ready_in = 1'b1;
        @(negedge clk);
        bus_if.bus_req_ready_in = 1'b0;
        checkOutput("rst_wait_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus_if.bus_resp_valid_in = 1'b1;
        bus_if.bus_rdata_in = 32'hDEAD_BEEF;
        @(negedge clk);
        bus_if.bus_resp_valid_in = 1'b0;
        last_load = 32'd0;
        checkAllClear("rst_wait");
        @(negedge clk);
        checkAllClear("rst_wait_after");
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        txn_count = 0;
        last_load = 32'd0;
        rst = 1'b1;
        req_valid = 1'b0;
        write = 1'b0;
        size = 3'b000;
        addr = 32'd0;
        store_data = 32'd0;
        bus_if.bus_req_ready_in = 1'b0;
        bus_if.bus_resp_valid_in = 1'b0;
        bus_if.bus_rdata_in = 32'd0;
        repeat (3) @(negedge clk);
        checkAllClear("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed cases");
        applyStimulus(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_FF7F, 0, 0);
        checkOutput("lb_value", load_data, 32'hFFFF_FF80);
        idleCycle();
        applyStimulus(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'd0, 1, 2);
        idleCycle();
        applyStimulus(1'b0, 3'b010, 32'h0000_0301, 32'd0, 32'd0, 0, 0);
        idleCycle();
        applyStimulus(1'b0, 3'b101, 32'h0000_0402, 32'd0, 32'h8001_0000, 5, 0);
        checkOutput("lhu_value", load_data, 32'h0000_8001);
        idleCycle();
        resetInWait();
        applyStimulus(1'b0, 3'b010, 32'h0000_0600, 32'd0, 32'hCAFE_F00D, 0, 0);
        applyStimulus(1'b1, 3'b010, 32'h0000_0604, 32'h5555_AAAA, 32'd0, 0, 0);
        idleCycle();
        applyStimulus(1'b1, 3'b100, 32'h0000_0700, 32'h0000_0011, 32'd0, 0, 0);
        idleCycle();

        $display("[TB] random cases");
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                          $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) idleCycle();
        end
        idleCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
